// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives the fetch PC to instruction memory,
// captures the returned word into a 2-entry prefetch FIFO and presents the
// head to decode over a valid/ready handshake. Redirects flush and retarget.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_DEPTH  = 4096,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] ent_pc_q   [FIFO_DEPTH];
  logic [31:0] ent_pc_d   [FIFO_DEPTH];
  logic [31:0] ent_inst_q [FIFO_DEPTH];
  logic [31:0] ent_inst_d [FIFO_DEPTH];
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        enq;
  logic        deq;
  logic        wr_idx;
  logic [32:0] pc_plus4;
  logic [31:0] next_pc;

  assign out_valid    = (count_q != 2'd0);
  assign deq          = out_valid && out_ready;
  assign enq          = !redirect_valid && ((count_q < 2'd2) || deq);
  // Free slot is just past the occupied ones; when full with a pop, it is the
  // slot being vacated (count_q[0] == 0 so wr_idx == rd_ptr_q).
  assign wr_idx       = rd_ptr_q ^ count_q[0];
  assign pc_plus4     = {1'b0, fetch_pc_q} + 33'd4;
  assign next_pc      = (pc_plus4 >= 33'(MEM_DEPTH)) ? 32'd0 : pc_plus4[31:0];

  assign inst_addr    = fetch_pc_q;
  assign out_inst     = ent_inst_q[rd_ptr_q];
  assign out_pc       = ent_pc_q[rd_ptr_q];
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

  // Next-state for PC, FIFO occupancy/pointer/storage and status counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    ent_pc_d      = ent_pc_q;
    ent_inst_d    = ent_inst_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    if (deq) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (redirect_valid) begin
      // Pointer is left alone so the outputs keep showing the last head.
      count_d    = 2'd0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (enq) begin
        ent_pc_d[wr_idx]   = fetch_pc_q;
        ent_inst_d[wr_idx] = inst;
        fetch_pc_d         = next_pc;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      // Advance past a popped head unless that empties the FIFO; when empty
      // the head slot keeps its last contents and is the next write target.
      if (deq && (enq || count_q == 2'd2)) begin
        rd_ptr_d = ~rd_ptr_q;
      end
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_pc_q[i]   <= 32'd0;
        ent_inst_q[i] <= 32'd0;
      end
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      ent_pc_q      <= ent_pc_d;
      ent_inst_q    <= ent_inst_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a combinational memory model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_DEPTH (4096),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_addr     (inst_addr),
    .inst          (inst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2008_0005;
      32'd4:   return 32'h2009_0003;
      32'd8:   return 32'h0109_5020;
      32'd12:  return 32'hAC0A_0000;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign inst = mem_word(inst_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = ready;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] exp_seq [4];

  initial begin
    exp_seq[0] = 32'h2008_0005;
    exp_seq[1] = 32'h2009_0003;
    exp_seq[2] = 32'h0109_5020;
    exp_seq[3] = 32'hAC0A_0000;

    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    @(negedge clk);

    // Sequential stream
    do_reset(1'b1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_inst_addr", inst_addr, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_valid", {31'd0, out_valid}, 32'd1);
      chk("seq_pc", out_pc, 32'(i * 4));
      chk("seq_inst", out_inst, exp_seq[i]);
      chk("seq_count", fetch_count, 32'(i));
    end
    step();
    chk("seq_count_final", fetch_count, 32'd4);

    // Backpressure
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_pc", out_pc, 32'd0);
    chk("bp_addr", inst_addr, 32'd8);
    chk("bp_count", fetch_count, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_drain_pc", out_pc, 32'(i * 4));
      chk("bp_drain_inst", out_inst, exp_seq[i]);
    end

    // Redirect with flush while full
    do_reset(1'b0);
    step();
    step();
    chk("rd_full_pc", out_pc, 32'd0);
    chk("rd_full_addr", inst_addr, 32'd8);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_addr", inst_addr, 32'h40);
    chk("rd_deq_count", fetch_count, 32'd1);
    step();
    chk("rd_tgt_valid", {31'd0, out_valid}, 32'd1);
    chk("rd_tgt_pc", out_pc, 32'h40);
    chk("rd_tgt_inst", out_inst, 32'hC0DE_0040);
    step();
    chk("rd_next_pc", out_pc, 32'h44);

    // Misaligned redirect, sticky flag
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0;
    chk("mis_addr", inst_addr, 32'h20);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    step();
    chk("mis_pc", out_pc, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
    chk("mis_addr2", inst_addr, 32'h100);

    // Wrap-around at MEM_DEPTH
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", inst_addr, 32'hFFC);
    step();
    chk("wrap_pc0", out_pc, 32'hFFC);
    chk("wrap_addr0", inst_addr, 32'h0);
    step();
    chk("wrap_pc1", out_pc, 32'h0);
    step();
    chk("wrap_pc2", out_pc, 32'h4);
    chk("wrap_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset mid-stream with full FIFO and redirect pending
    out_ready = 1'b0;
    step();
    step();
    chk("mrst_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_addr", inst_addr, 32'd0);
    chk("mrst_count", fetch_count, 32'd0);
    chk("mrst_err", {31'd0, misalign_err}, 32'd0);
    chk("mrst_out_pc", out_pc, 32'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    step();
    chk("mrst_restart_pc", out_pc, 32'd0);
    chk("mrst_restart_valid", {31'd0, out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
